// File: rtl/mem_access_ctrl.sv
// Data-memory access stage: decodes load/store ops, aligns lanes, runs the
// req/ack handshake with a variable-latency memory and returns raw load words.
`timescale 1ns/1ps
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [5:0]  ex_opcode,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic [1:0]  ld_offset,
  output logic [5:0]  ld_opcode,
  output logic        err_misaligned,
  output logic        err_timeout
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned OP_W  = 6;
  localparam int unsigned DW    = 32;

  localparam logic [OP_W-1:0] OP_LB  = 6'h20;
  localparam logic [OP_W-1:0] OP_LH  = 6'h21;
  localparam logic [OP_W-1:0] OP_LW  = 6'h23;
  localparam logic [OP_W-1:0] OP_LBU = 6'h24;
  localparam logic [OP_W-1:0] OP_LHU = 6'h25;
  localparam logic [OP_W-1:0] OP_SB  = 6'h28;
  localparam logic [OP_W-1:0] OP_SH  = 6'h29;
  localparam logic [OP_W-1:0] OP_SW  = 6'h2B;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [DW-1:0]     mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
  logic [1:0]        req_offset_q, req_offset_d;
  logic [OP_W-1:0]   req_opcode_q, req_opcode_d;
  logic              ld_valid_q, ld_valid_d;
  logic [DW-1:0]     ld_data_q, ld_data_d;
  logic [1:0]        ld_offset_q, ld_offset_d;
  logic [OP_W-1:0]   ld_opcode_q, ld_opcode_d;
  logic              err_mis_q, err_mis_d;
  logic              err_to_q, err_to_d;

  logic              is_load, is_store, is_word, is_half, misaligned, accept;
  logic              timeout_hit;
  logic [3:0]        be_c;
  logic [DW-1:0]     wdata_c;

  // Opcode decode and alignment check
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_word  = 1'b0;
    is_half  = 1'b0;
    unique case (ex_opcode)
      OP_LB, OP_LBU: is_load = 1'b1;
      OP_LH, OP_LHU: begin is_load = 1'b1; is_half = 1'b1; end
      OP_LW:         begin is_load = 1'b1; is_word = 1'b1; end
      OP_SB:         is_store = 1'b1;
      OP_SH:         begin is_store = 1'b1; is_half = 1'b1; end
      OP_SW:         begin is_store = 1'b1; is_word = 1'b1; end
      default:       ;
    endcase
    misaligned = (is_word && (ex_addr[1:0] != 2'b00)) || (is_half && ex_addr[0]);
    accept     = rst_n && (state_q == IDLE) && ex_valid && (is_load || is_store) && !misaligned;
  end

  // Store lane placement; halfword lanes are big-endian within the word
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = ex_wdata;
    if (ex_opcode == OP_SB) begin
      be_c    = 4'(4'b0001 << ex_addr[1:0]);
      wdata_c = {4{ex_wdata[7:0]}};
    end else if (ex_opcode == OP_SH) begin
      be_c    = ex_addr[1] ? 4'b0011 : 4'b1100;
      wdata_c = {2{ex_wdata[15:0]}};
    end
  end

  assign timeout_hit = (state_q == BUSY) && !mem_ack && (cnt_q == CNT_LAST);
  assign stall       = accept || ((state_q == BUSY) && !mem_ack && !timeout_hit);

  // Next-state and registered output logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    req_offset_d = req_offset_q;
    req_opcode_d = req_opcode_q;
    ld_valid_d   = 1'b0;
    ld_data_d    = ld_data_q;
    ld_offset_d  = ld_offset_q;
    ld_opcode_d  = ld_opcode_q;
    err_mis_d    = 1'b0;
    err_to_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        err_mis_d = ex_valid && (is_load || is_store) && misaligned;
        if (accept) begin
          state_d      = BUSY;
          cnt_d        = '0;
          mem_req_d    = 1'b1;
          mem_we_d     = is_store;
          mem_addr_d   = {ex_addr[31:2], 2'b00};
          mem_be_d     = be_c;
          mem_wdata_d  = wdata_c;
          req_offset_d = ex_addr[1:0];
          req_opcode_d = ex_opcode;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_ack || timeout_hit) begin
          state_d   = IDLE;
          cnt_d     = '0;
          mem_req_d = 1'b0;
          err_to_d  = !mem_ack;
          if (!mem_we_q) begin
            ld_valid_d  = 1'b1;
            ld_data_d   = mem_ack ? mem_rdata : '0;
            ld_offset_d = req_offset_q;
            ld_opcode_d = req_opcode_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
      req_offset_q <= '0;
      req_opcode_q <= '0;
      ld_valid_q   <= 1'b0;
      ld_data_q    <= '0;
      ld_offset_q  <= '0;
      ld_opcode_q  <= '0;
      err_mis_q    <= 1'b0;
      err_to_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      req_offset_q <= req_offset_d;
      req_opcode_q <= req_opcode_d;
      ld_valid_q   <= ld_valid_d;
      ld_data_q    <= ld_data_d;
      ld_offset_q  <= ld_offset_d;
      ld_opcode_q  <= ld_opcode_d;
      err_mis_q    <= err_mis_d;
      err_to_q     <= err_to_d;
    end
  end

  assign mem_req        = mem_req_q;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_be         = mem_be_q;
  assign mem_wdata      = mem_wdata_q;
  assign ld_valid       = ld_valid_q;
  assign ld_data        = ld_data_q;
  assign ld_offset      = ld_offset_q;
  assign ld_opcode      = ld_opcode_q;
  assign err_misaligned = err_mis_q;
  assign err_timeout    = err_to_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed and random transactions against a
// transaction-level memory model with byte-lane writes.
`timescale 1ns/1ps
module tb_mem_access_ctrl;

  localparam int unsigned T = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [5:0]  ex_opcode;
  logic [31:0] ex_addr, ex_wdata;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic [1:0]  ld_offset;
  logic [5:0]  ld_opcode;
  logic        err_misaligned, err_timeout;

  mem_access_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .stall(stall), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_offset(ld_offset), .ld_opcode(ld_opcode), .err_misaligned(err_misaligned),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] mem_model [int];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_ld(input logic [5:0] op);
    return op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
  endfunction

  function automatic bit is_st(input logic [5:0] op);
    return op inside {6'h28, 6'h29, 6'h2B};
  endfunction

  function automatic bit is_mis(input logic [5:0] op, input logic [31:0] a);
    if (op inside {6'h23, 6'h2B}) return a % 4 != 0;
    if (op inside {6'h21, 6'h25, 6'h29}) return a % 2 != 0;
    return 1'b0;
  endfunction

  // Byte k of a word occupies bits 8k+7:8k; halfwords are placed big-endian
  function automatic logic [3:0] exp_be(input logic [5:0] op, input logic [1:0] off);
    if (op == 6'h28) return 4'(1 << off);
    if (op == 6'h29) return (off == 2'd0) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [5:0] op, input logic [31:0] wd);
    if (op == 6'h28) return wd[7:0] * 32'h0101_0101;
    if (op == 6'h29) return wd[15:0] * 32'h0001_0001;
    return wd;
  endfunction

  function automatic int word_key(input logic [31:0] a);
    return int'(a / 4);
  endfunction

  function automatic logic [31:0] read_word(input logic [31:0] a);
    if (mem_model.exists(word_key(a))) return mem_model[word_key(a)];
    return 32'hC0DE_0000 ^ (a / 4);
  endfunction

  task automatic write_word(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    logic [31:0] w;
    w = read_word(a);
    for (int k = 0; k < 4; k++)
      if (be[k]) w[8*k +: 8] = d[8*k +: 8];
    mem_model[word_key(a)] = w;
  endtask

  // Downstream halfword extraction that must undo the store lane map
  function automatic logic [31:0] half_of(input logic [31:0] w, input logic [1:0] off);
    return (off == 2'd2) ? (w % 32'h1_0000) : (w / 32'h1_0000);
  endfunction

  task automatic step(input logic v, input logic [5:0] op, input logic [31:0] a,
                      input logic [31:0] wd, input logic ack, input logic [31:0] rd);
    @(negedge clk);
    ex_valid = v; ex_opcode = op; ex_addr = a; ex_wdata = wd;
    mem_ack = ack; mem_rdata = rd;
    #1;
  endtask

  task automatic idle_check();
    step(1'b0, 6'h00, 32'h0, 32'h0, 1'($urandom_range(0, 1)), $urandom);
    check("idle_req", mem_req, 1'b0);
    check("idle_ldv", ld_valid, 1'b0);
    check("idle_emis", err_misaligned, 1'b0);
    check("idle_eto", err_timeout, 1'b0);
  endtask

  // lat: BUSY cycles after mem_req rises before ack; lat >= T means no ack
  task automatic do_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                       input int lat);
    bit ld, st, done, acked, ack_now;
    logic [31:0] rd, last_rd;
    ld = is_ld(op); st = is_st(op);
    done = 0; acked = 0; last_rd = 0;
    step(1'b1, op, a, wd, 1'($urandom_range(0, 1)), $urandom);
    if (!(ld || st)) begin
      check("nop_stall", stall, 1'b0);
      idle_check();
      return;
    end
    if (is_mis(op, a)) begin
      check("mis_stall", stall, 1'b0);
      step(1'b0, 6'h00, 32'h0, 32'h0, 1'b0, 32'h0);
      check("mis_err", err_misaligned, 1'b1);
      check("mis_req", mem_req, 1'b0);
      check("mis_ldv", ld_valid, 1'b0);
      idle_check();
      return;
    end
    check("acc_stall", stall, 1'b1);
    for (int i = 0; i < int'(T) && !done; i++) begin
      ack_now = (i == lat);
      rd = ld ? read_word(a) : $urandom;
      step(1'b1, op, a, wd, ack_now, rd);
      if (i == 0) begin
        check("req_addr", mem_addr, {a[31:2], 2'b00});
        check("req_be", mem_be, exp_be(op, a[1:0]));
        check("req_we", mem_we, st);
        if (st) check("req_wdata", mem_wdata, exp_wdata(op, wd));
      end
      check("busy_req", mem_req, 1'b1);
      check("busy_stall", stall, !(ack_now || i == int'(T) - 1));
      if (ack_now || i == int'(T) - 1) begin
        done = 1; acked = ack_now; last_rd = rd;
        if (ack_now && st) write_word(a, exp_be(op, a[1:0]), exp_wdata(op, wd));
      end
    end
    step(1'b0, 6'h00, 32'h0, 32'h0, 1'($urandom_range(0, 1)), $urandom);
    check("done_req", mem_req, 1'b0);
    check("done_ldv", ld_valid, ld);
    check("done_eto", err_timeout, !acked);
    if (ld) begin
      check("ld_data", ld_data, acked ? last_rd : 32'h0);
      check("ld_offset", ld_offset, a[1:0]);
      check("ld_opcode", ld_opcode, op);
    end
    idle_check();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ops [12];
    logic [5:0] op;
    logic [31:0] a;
    int r, lat;
    ops = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B,
            6'h00, 6'h0F, 6'h22, 6'h2A};

    rst_n = 1'b0; ex_valid = 1'b1; ex_opcode = 6'h23; ex_addr = 32'h100;
    ex_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    #12;
    check("rst_stall", stall, 1'b0);
    check("rst_req", mem_req, 1'b0);
    check("rst_be", mem_be, 4'h0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_ldv", ld_valid, 1'b0);
    check("rst_ldopc", ld_opcode, 6'h0);
    @(negedge clk); rst_n = 1'b1; ex_valid = 1'b0;

    mem_model[word_key(32'h100)] = 32'h1234_5678;
    do_op(6'h23, 32'h100, 32'h0, 3);
    check("lw_data_val", ld_data, 32'h1234_5678);
    do_op(6'h28, 32'h203, 32'h0000_00A5, 1);
    do_op(6'h29, 32'h302, 32'h0000_BEEF, 0);
    do_op(6'h29, 32'h300, 32'h0000_BEEF, 2);
    do_op(6'h25, 32'h302, 32'h0, 1);
    check("rt_lhu", half_of(ld_data, ld_offset), 32'h0000_BEEF);
    do_op(6'h21, 32'h300, 32'h0, 4);
    check("rt_lh_hi", half_of(ld_data, ld_offset), 32'h0000_BEEF);
    do_op(6'h23, 32'h101, 32'h0, 0);
    do_op(6'h21, 32'h103, 32'h0, 0);
    do_op(6'h23, 32'h104, 32'h0, T + 3);
    do_op(6'h2B, 32'h108, 32'h5555_AAAA, T + 3);
    do_op(6'h23, 32'h10C, 32'h0, T - 1);

    // Reset in the middle of an outstanding access
    step(1'b1, 6'h23, 32'h500, 32'h0, 1'b0, 32'h0);
    step(1'b1, 6'h23, 32'h500, 32'h0, 1'b0, 32'h0);
    step(1'b1, 6'h23, 32'h500, 32'h0, 1'b0, 32'h0);
    check("pre_rst_req", mem_req, 1'b1);
    @(negedge clk); rst_n = 1'b0; #1;
    check("midrst_req", mem_req, 1'b0);
    check("midrst_stall", stall, 1'b0);
    check("midrst_ldv", ld_valid, 1'b0);
    check("midrst_eto", err_timeout, 1'b0);
    check("midrst_addr", mem_addr, 32'h0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1; ex_valid = 1'b0;
    do_op(6'h23, 32'h500, 32'h0, 2);

    for (int n = 0; n < 50; n++) begin
      op = ops[$urandom_range(0, 11)];
      a  = 32'h400 + $urandom_range(0, 15);
      r  = $urandom_range(0, 9);
      lat = (r < 7) ? r : (r == 7) ? int'(T) - 1 : int'(T) + 3;
      do_op(op, a, $urandom, lat);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
